// File: rtl/mem_burst_responder.sv
// mem_burst_responder
//
// Synthesizable target end of the enable/rw/access_size word memory protocol.
// It accepts single-word and 4/8/16-word bursts, performs beat 0 in the accept
// cycle, and streams read data with one cycle of latency. Beats that fall outside
// [start_addr, start_addr + depth) are not written, read back as zero, and raise
// addr_err in the following cycle.
//
// Optional feature macro: MEM_BURST_WRAP_EN
//   defined   : burst pointer wraps within the N-word aligned block
//               (critical-word-first)
//   undefined : burst pointer increments linearly
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   address      in   byte address of the first beat; bits [1:0] are ignored
//   data_in      in   write data, sampled on every write beat
//   access_size  in   burst length 00=1, 01=4, 10=8, 11=16 words
//   rw           in   0 = write, 1 = read
//   enable       in   request valid / burst continue
//   busy         out  burst in progress; new requests are not accepted
//   data_out     out  read data, valid for one cycle after each read beat
//   addr_err     out  previous beat was outside the address window
module mem_burst_responder #(
  parameter int unsigned              data_width    = 32,
  parameter int unsigned              address_width = 32,
  parameter int unsigned              depth         = 1048576,
  parameter logic [address_width-1:0] start_addr    = 32'h80020000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [address_width-1:0] address,
  input  logic [data_width-1:0]    data_in,
  input  logic [1:0]               access_size,
  input  logic                     rw,
  input  logic                     enable,
  output logic                     busy,
  output logic [data_width-1:0]    data_out,
  output logic                     addr_err
);

  localparam int unsigned Words = depth / 4;
  localparam int unsigned PtrW  = $clog2(Words);
  localparam int unsigned OffW  = address_width - 2;
  localparam logic [OffW-1:0] WordsLim = OffW'(Words);

  typedef enum logic [1:0] {StIdle, StWburst, StRburst} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               beats_left_q, beats_left_d;
  logic [OffW-1:0]          woff_q, woff_d;
  logic [OffW-1:0]          cur_off, next_off;
  logic [address_width-1:0] byte_off;
  logic [PtrW-1:0]          wptr;
  logic                     beat_en, beat_rd, cur_oor;

  logic [data_width-1:0] mem [Words];

  // Beats remaining after beat 0 for each encoded burst length.
  function automatic logic [3:0] last_beat_idx(input logic [1:0] size);
    logic [3:0] idx;
    case (size)
      2'b01:   idx = 4'd3;
      2'b10:   idx = 4'd7;
      2'b11:   idx = 4'd15;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

  // Offset wraps modulo 2^address_width, so addresses below start_addr land far
  // above the window and are caught by the same single compare.
  assign byte_off = address - start_addr;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^byte_off[1:0];

  // Beat 0 is served straight from the request; later beats use the stored offset.
  assign cur_off = (state_q == StIdle) ? byte_off[address_width-1:2] : woff_q;
  assign cur_oor = (cur_off >= WordsLim);
  assign wptr    = cur_off[PtrW-1:0];

`ifdef MEM_BURST_WRAP_EN
  logic [1:0]      size_q, cur_size;
  logic [OffW-1:0] wrap_mask;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      size_q <= 2'b00;
    end else if ((state_q == StIdle) && enable) begin
      size_q <= access_size;
    end
  end

  assign cur_size = (state_q == StIdle) ? access_size : size_q;

  always_comb begin
    wrap_mask = '0;
    case (cur_size)
      2'b01:   wrap_mask = OffW'(3);
      2'b10:   wrap_mask = OffW'(7);
      2'b11:   wrap_mask = OffW'(15);
      default: wrap_mask = '0;
    endcase
  end

  // Keep the block-select bits, advance only the in-block index.
  assign next_off = (cur_off & ~wrap_mask) | ((cur_off + OffW'(1)) & wrap_mask);
`else
  assign next_off = cur_off + OffW'(1);
`endif

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    woff_d       = woff_q;
    beat_en      = 1'b0;
    beat_rd      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          beat_en      = 1'b1;
          beat_rd      = rw;
          beats_left_d = last_beat_idx(access_size);
          if (access_size != 2'b00) begin
            state_d = rw ? StRburst : StWburst;
          end
        end
      end
      StWburst, StRburst: begin
        if (enable) begin
          beat_en      = 1'b1;
          beat_rd      = (state_q == StRburst);
          beats_left_d = beats_left_q - 4'd1;
          if (beats_left_q == 4'd1) begin
            state_d = StIdle;
          end
        end else begin
          // Abort: no beat, already-written words stay in memory.
          state_d      = StIdle;
          beats_left_d = 4'd0;
        end
      end
      default: begin
        state_d      = StIdle;
        beats_left_d = 4'd0;
      end
    endcase
    if (beat_en) begin
      woff_d = next_off;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      beats_left_q <= 4'd0;
      woff_q       <= '0;
      data_out     <= '0;
      addr_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      woff_q       <= woff_d;
      addr_err     <= beat_en & cur_oor;
      if (beat_en && beat_rd) begin
        data_out <= cur_oor ? '0 : mem[wptr];
      end
    end
  end

  // Array has no reset: contents survive reset and aborted bursts.
  always_ff @(posedge clock) begin
    if (beat_en && !beat_rd && !cur_oor) begin
      mem[wptr] <= data_in;
    end
  end

  assign busy = (state_q != StIdle);

endmodule
